// File: rtl/scaler_pkg.sv
// scaler_pkg: shared definitions for the scaler engine.
//   mode_e   - MODE port encodings (replicate, decimate, block average, copy)
//   state_e  - engine FSM states
//   out_dims - output image width/height for a given mode and factor
package scaler_pkg;

    typedef enum logic [1:0] {
        MODE_REP = 2'b00,
        MODE_DEC = 2'b01,
        MODE_AVG = 2'b10,
        MODE_CPY = 2'b11
    } mode_e;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_WAIT,
        S_WRITE,
        S_DONE
    } state_e;

    // Factor is 2 (scale4=0) or 4 (scale4=1); scaling is done with shifts.
    function automatic void out_dims(
        input  int unsigned src_w,
        input  int unsigned src_h,
        input  mode_e       mode,
        input  logic        scale4,
        output int unsigned out_w,
        output int unsigned out_h
    );
        int unsigned sh;
        sh = scale4 ? 2 : 1;
        case (mode)
            MODE_REP: begin
                out_w = src_w << sh;
                out_h = src_h << sh;
            end
            MODE_DEC, MODE_AVG: begin
                out_w = src_w >> sh;
                out_h = src_h >> sh;
            end
            default: begin
                out_w = src_w;
                out_h = src_h;
            end
        endcase
    endfunction

endpackage

// File: rtl/scaler_addr_gen.sv
// scaler_addr_gen: destination x/y raster counters, source and destination
// row-base registers and the block-average read offset.
//   CLK, RESET    - clock, synchronous active-high reset
//   init          - clear all counters (frame start)
//   adv           - advance to the next output pixel (write accepted)
//   step_blk      - advance the block-average read offset (row-major)
//   mode, scale4  - latched frame mode and factor (0 = 2, 1 = 4)
//   r_addr        - source read address for the current pixel/offset
//   w_addr        - destination write address for the current pixel
//   blk_last      - current offset is the last one of the F x F block
//   last_pix      - current pixel is (OUT_W-1, OUT_H-1)
module scaler_addr_gen
    import scaler_pkg::*;
#(
    parameter int unsigned SRC_W  = 160,
    parameter int unsigned SRC_H  = 120,
    parameter int unsigned SRC_AW = $clog2(SRC_W * SRC_H),
    parameter int unsigned DST_AW = $clog2(SRC_W * SRC_H * 16)
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              init,
    input  logic              adv,
    input  logic              step_blk,
    input  mode_e             mode,
    input  logic              scale4,
    output logic [SRC_AW-1:0] r_addr,
    output logic [DST_AW-1:0] w_addr,
    output logic              blk_last,
    output logic              last_pix
);

    localparam int unsigned XW = $clog2(SRC_W * 4) + 1;
    localparam int unsigned YW = $clog2(SRC_H * 4) + 1;

    logic [XW-1:0]     x;
    logic [XW-1:0]     out_w;
    logic [YW-1:0]     y;
    logic [YW-1:0]     out_h;
    logic [1:0]        bx;
    logic [1:0]        by;
    logic [1:0]        fmax;
    logic [1:0]        sh;
    logic [SRC_AW-1:0] s_row;
    logic [SRC_AW-1:0] blk_row;
    logic [SRC_AW-1:0] sx;
    logic [SRC_AW-1:0] s_step;
    logic [DST_AW-1:0] w_row;
    int unsigned       ow;
    int unsigned       oh;

    assign sh   = scale4 ? 2'd2 : 2'd1;
    assign fmax = scale4 ? 2'd3 : 2'd1;

    always_comb begin
        ow = 0;
        oh = 0;
        out_dims(SRC_W, SRC_H, mode, scale4, ow, oh);
        out_w = XW'(ow);
        out_h = YW'(oh);
    end

    // Source column within the row, and the source row-base increment
    // applied when y advances. Replicate only moves to a new source row
    // once every F output rows.
    always_comb begin
        sx     = '0;
        s_step = '0;
        case (mode)
            MODE_REP: begin
                sx     = SRC_AW'(x >> sh);
                s_step = ((2'(y + YW'(1)) & fmax) == 2'd0) ? SRC_AW'(SRC_W) : '0;
            end
            MODE_DEC, MODE_AVG: begin
                sx     = SRC_AW'(x << sh);
                s_step = SRC_AW'(SRC_W) << sh;
            end
            default: begin
                sx     = SRC_AW'(x);
                s_step = SRC_AW'(SRC_W);
            end
        endcase
    end

    assign r_addr   = s_row + sx + blk_row + SRC_AW'(bx);
    assign w_addr   = w_row + DST_AW'(x);
    assign blk_last = (bx == fmax) && (by == fmax);
    assign last_pix = (x == out_w - 1'b1) && (y == out_h - 1'b1);

    always_ff @(posedge CLK) begin
        if (RESET || init) begin
            x       <= '0;
            y       <= '0;
            bx      <= '0;
            by      <= '0;
            s_row   <= '0;
            blk_row <= '0;
            w_row   <= '0;
        end else begin
            if (step_blk) begin
                if (bx == fmax) begin
                    bx <= '0;
                    if (by == fmax) begin
                        by      <= '0;
                        blk_row <= '0;
                    end else begin
                        by      <= by + 2'd1;
                        blk_row <= blk_row + SRC_AW'(SRC_W);
                    end
                end else begin
                    bx <= bx + 2'd1;
                end
            end
            // Counters freeze on the last pixel so no address leaves the image.
            if (adv && !last_pix) begin
                if (x == out_w - 1'b1) begin
                    x     <= '0;
                    y     <= y + YW'(1);
                    w_row <= w_row + DST_AW'(out_w);
                    s_row <= s_row + s_step;
                end else begin
                    x <= x + XW'(1);
                end
            end
        end
    end

endmodule

// File: rtl/scaler_engine.sv
// scaler_engine: raster-order image scaler between the source and
// destination frame RAMs (2x/4x replicate, decimate, block average, copy).
//   CLK, RESET  - clock, synchronous active-high reset
//   START       - one-cycle start request, accepted only when idle
//   MODE, SCALE - frame mode and factor, latched at START
//   PIXEL_IN    - source RAM read data, RD_LAT cycles after R_ADDR
//   WR_READY    - destination accepts the write this cycle
//   R_ADDR      - source RAM read address
//   W_ADDR, PIXEL_OUT, WREN - destination write port
//   BUSY, DONE  - frame in progress / one-cycle completion pulse
module scaler_engine
    import scaler_pkg::*;
#(
    parameter int unsigned PIX_W  = 8,
    parameter int unsigned SRC_W  = 160,
    parameter int unsigned SRC_H  = 120,
    parameter int unsigned RD_LAT = 1,
    parameter int unsigned SRC_AW = $clog2(SRC_W * SRC_H),
    parameter int unsigned DST_AW = $clog2(SRC_W * SRC_H * 16)
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              START,
    input  logic [1:0]        MODE,
    input  logic              SCALE,
    input  logic [PIX_W-1:0]  PIXEL_IN,
    input  logic              WR_READY,
    output logic [SRC_AW-1:0] R_ADDR,
    output logic [DST_AW-1:0] W_ADDR,
    output logic [PIX_W-1:0]  PIXEL_OUT,
    output logic              WREN,
    output logic              BUSY,
    output logic              DONE
);

    localparam int unsigned ACC_W = PIX_W + 4;

    state_e            state;
    state_e            state_nxt;
    mode_e             mode_q;
    logic              scale_q;
    logic [RD_LAT-1:0] rd_pipe;
    logic [1:0]        wcnt;
    logic [ACC_W-1:0]  acc;
    logic [PIX_W-1:0]  result;
    logic [SRC_AW-1:0] r_addr;
    logic [DST_AW-1:0] w_addr;
    logic              blk_last;
    logic              last_pix;
    logic              is_avg;
    logic              init;
    logic              issue;
    logic              step_blk;
    logic              adv;
    logic              wren;
    logic              done;

    assign is_avg = (mode_q == MODE_AVG);

    scaler_addr_gen #(
        .SRC_W (SRC_W),
        .SRC_H (SRC_H),
        .SRC_AW(SRC_AW),
        .DST_AW(DST_AW)
    ) u_addr_gen (
        .CLK     (CLK),
        .RESET   (RESET),
        .init    (init),
        .adv     (adv),
        .step_blk(step_blk),
        .mode    (mode_q),
        .scale4  (scale_q),
        .r_addr  (r_addr),
        .w_addr  (w_addr),
        .blk_last(blk_last),
        .last_pix(last_pix)
    );

    always_comb begin
        state_nxt = state;
        init      = 1'b0;
        issue     = 1'b0;
        step_blk  = 1'b0;
        adv       = 1'b0;
        wren      = 1'b0;
        done      = 1'b0;
        case (state)
            S_IDLE: begin
                if (START) begin
                    init      = 1'b1;
                    state_nxt = S_FETCH;
                end
            end
            S_FETCH: begin
                issue = 1'b1;
                if (is_avg) begin
                    step_blk = 1'b1;
                    if (blk_last) state_nxt = S_WAIT;
                end else begin
                    state_nxt = S_WAIT;
                end
            end
            S_WAIT: begin
                if (wcnt == 2'(RD_LAT - 1)) state_nxt = S_WRITE;
            end
            S_WRITE: begin
                wren = 1'b1;
                if (WR_READY) begin
                    adv       = 1'b1;
                    state_nxt = last_pix ? S_DONE : S_FETCH;
                end
            end
            S_DONE: begin
                done      = 1'b1;
                state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // rd_pipe tracks in-flight reads; its top bit marks the cycle whose
    // PIXEL_IN belongs to a read, so block-average accumulation overlaps
    // issue. The accumulator is cleared on every entry into FETCH.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state   <= S_IDLE;
            mode_q  <= MODE_REP;
            scale_q <= 1'b0;
            rd_pipe <= '0;
            wcnt    <= '0;
            acc     <= '0;
        end else begin
            state <= state_nxt;
            if (init) begin
                mode_q  <= mode_e'(MODE);
                scale_q <= SCALE;
            end
            rd_pipe <= (rd_pipe << 1) | RD_LAT'(issue);
            wcnt    <= (state == S_WAIT) ? wcnt + 2'd1 : 2'd0;
            if (state_nxt == S_FETCH && state != S_FETCH)
                acc <= '0;
            else if (rd_pipe[RD_LAT-1])
                acc <= is_avg ? acc + ACC_W'(PIXEL_IN) : ACC_W'(PIXEL_IN);
        end
    end

    assign result    = is_avg ? PIX_W'(scale_q ? (acc >> 4) : (acc >> 2))
                              : PIX_W'(acc);
    assign R_ADDR    = (state == S_FETCH) ? r_addr : '0;
    assign WREN      = wren;
    assign W_ADDR    = wren ? w_addr : '0;
    assign PIXEL_OUT = wren ? result : '0;
    assign BUSY      = (state == S_FETCH) || (state == S_WAIT) || (state == S_WRITE);
    assign DONE      = done;

endmodule

// File: tb/tb_scaler_engine.sv
// tb_scaler_engine: self-checking bench for scaler_engine with an 8x4
// source frame whose RAM holds value = address, read latency 2.
module tb_scaler_engine;
    import scaler_pkg::*;

    localparam int unsigned SW  = 8;
    localparam int unsigned SH  = 4;
    localparam int unsigned SAW = 5;
    localparam int unsigned DAW = 9;

    logic           CLK = 1'b0;
    logic           RESET = 1'b1;
    logic           START = 1'b0;
    logic [1:0]     MODE = 2'b00;
    logic           SCALE = 1'b0;
    logic [7:0]     PIXEL_IN;
    logic           WR_READY = 1'b1;
    logic [SAW-1:0] R_ADDR;
    logic [DAW-1:0] W_ADDR;
    logic [7:0]     PIXEL_OUT;
    logic           WREN;
    logic           BUSY;
    logic           DONE;

    int n_cmp = 0;
    int n_bad = 0;

    scaler_engine #(
        .PIX_W (8),
        .SRC_W (SW),
        .SRC_H (SH),
        .RD_LAT(2)
    ) dut (
        .CLK      (CLK),
        .RESET    (RESET),
        .START    (START),
        .MODE     (MODE),
        .SCALE    (SCALE),
        .PIXEL_IN (PIXEL_IN),
        .WR_READY (WR_READY),
        .R_ADDR   (R_ADDR),
        .W_ADDR   (W_ADDR),
        .PIXEL_OUT(PIXEL_OUT),
        .WREN     (WREN),
        .BUSY     (BUSY),
        .DONE     (DONE)
    );

    always #5 CLK = ~CLK;

    // Source RAM: two-stage read pipeline, contents equal the address.
    logic [7:0] p1 = '0;
    logic [7:0] p2 = '0;
    always @(posedge CLK) begin
        p1 <= 8'(R_ADDR);
        p2 <= p1;
    end
    assign PIXEL_IN = p2;

    // Write / completion log.
    int wa[$];
    int wd[$];
    int wc[$];
    int wb[$];
    int cyc = 0;
    int done_cnt = 0;
    int done_cyc = 0;
    int done_busy = 0;

    always @(negedge CLK) begin
        cyc <= cyc + 1;
        if (WREN && WR_READY) begin
            wa.push_back(int'(W_ADDR));
            wd.push_back(int'(PIXEL_OUT));
            wc.push_back(cyc);
            wb.push_back(int'(BUSY));
        end
        if (DONE) begin
            done_cnt  <= done_cnt + 1;
            done_cyc  <= cyc;
            done_busy <= int'(BUSY);
        end
    end

    // Reference model
    function automatic int src_px(int sx, int sy);
        return (sy * SW + sx) % 256;
    endfunction

    function automatic int fac(int s);
        return (s != 0) ? 4 : 2;
    endfunction

    function automatic int out_w_of(int m, int f);
        if (m == 0) return SW * f;
        if (m == 3) return SW;
        return SW / f;
    endfunction

    function automatic int out_h_of(int m, int f);
        if (m == 0) return SH * f;
        if (m == 3) return SH;
        return SH / f;
    endfunction

    function automatic int exp_pix(int m, int f, int x, int y);
        int s;
        s = 0;
        case (m)
            0: return src_px(x / f, y / f);
            1: return src_px(x * f, y * f);
            2: begin
                for (int by = 0; by < f; by++)
                    for (int bx = 0; bx < f; bx++)
                        s += src_px(x * f + bx, y * f + by);
                return s / (f * f);
            end
            default: return src_px(x, y);
        endcase
    endfunction

    // Stimulus helpers
    task automatic clear_log;
        wa.delete();
        wd.delete();
        wc.delete();
        wb.delete();
        done_cnt = 0;
    endtask

    task automatic do_start(input logic [1:0] m, input logic s);
        @(posedge CLK); #1;
        MODE  = m;
        SCALE = s;
        START = 1'b1;
        @(posedge CLK); #1;
        START = 1'b0;
    endtask

    task automatic wait_frame(input int budget, input bit rnd, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(posedge CLK); #1;
            if (rnd) WR_READY = ($urandom_range(0, 3) != 0);
            if (done_cnt > 0) begin
                ok = 1'b1;
                break;
            end
        end
        WR_READY = 1'b1;
    endtask

    // Tests
    task automatic test_reset;
        RESET = 1'b1;
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        n_cmp++; if (WREN !== 1'b0) begin n_bad++; $display("FAIL reset_wren got %0b want 0", WREN); end
        n_cmp++; if (BUSY !== 1'b0) begin n_bad++; $display("FAIL reset_busy got %0b want 0", BUSY); end
        n_cmp++; if (DONE !== 1'b0) begin n_bad++; $display("FAIL reset_done got %0b want 0", DONE); end
        n_cmp++; if (R_ADDR !== '0) begin n_bad++; $display("FAIL reset_raddr got %0d want 0", R_ADDR); end
        n_cmp++; if (W_ADDR !== '0) begin n_bad++; $display("FAIL reset_waddr got %0d want 0", W_ADDR); end
        n_cmp++; if (PIXEL_OUT !== '0) begin n_bad++; $display("FAIL reset_pixout got %0d want 0", PIXEL_OUT); end
        @(posedge CLK); #1;
        RESET = 1'b0;
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        n_cmp++; if (BUSY !== 1'b0) begin n_bad++; $display("FAIL idle_busy got %0b want 0", BUSY); end
    endtask

    task automatic test_replicate;
        bit ok;
        int bad_per;
        clear_log();
        WR_READY = 1'b1;
        do_start(2'b00, 1'b0);
        n_cmp++; if (BUSY !== 1'b1) begin n_bad++; $display("FAIL rep_busy_rise got %0b want 1", BUSY); end
        wait_frame(1500, 1'b0, ok);
        n_cmp++; if (ok !== 1'b1) begin n_bad++; $display("FAIL rep_timeout got no DONE want DONE"); end
        n_cmp++; if (wa.size() !== 128) begin n_bad++; $display("FAIL rep_count got %0d want 128", wa.size()); end
        if (wa.size() == 128) begin
            n_cmp++; if (wa[17] !== 17 || wd[17] !== 0) begin n_bad++; $display("FAIL rep_px17 got a=%0d d=%0d want a=17 d=0", wa[17], wd[17]); end
            n_cmp++; if (wa[127] !== 127 || wd[127] !== 31) begin n_bad++; $display("FAIL rep_px127 got a=%0d d=%0d want a=127 d=31", wa[127], wd[127]); end
            n_cmp++; if (done_cyc - wc[127] !== 1) begin n_bad++; $display("FAIL rep_done_lat got %0d want 1", done_cyc - wc[127]); end
            bad_per = 0;
            for (int i = 1; i < 128; i++) if (wc[i] - wc[i-1] != 4) bad_per++;
            n_cmp++; if (bad_per !== 0) begin n_bad++; $display("FAIL rep_period got %0d off-period pixels want 0", bad_per); end
            for (int i = 0; i < 128; i++) begin
                n_cmp++;
                if (wa[i] !== i || wd[i] !== exp_pix(0, 2, i % 16, i / 16)) begin
                    n_bad++;
                    $display("FAIL rep_pix[%0d] got a=%0d d=%0d want a=%0d d=%0d", i, wa[i], wd[i], i, exp_pix(0, 2, i % 16, i / 16));
                end
            end
        end
    endtask

    task automatic test_decimate;
        bit ok;
        clear_log();
        do_start(2'b01, 1'b1);
        wait_frame(200, 1'b0, ok);
        n_cmp++; if (ok !== 1'b1) begin n_bad++; $display("FAIL dec_timeout got no DONE want DONE"); end
        n_cmp++; if (wa.size() !== 2) begin n_bad++; $display("FAIL dec_count got %0d want 2", wa.size()); end
        if (wa.size() == 2) begin
            n_cmp++; if (wa[0] !== 0 || wd[0] !== 0) begin n_bad++; $display("FAIL dec_px0 got a=%0d d=%0d want a=0 d=0", wa[0], wd[0]); end
            n_cmp++; if (wa[1] !== 1 || wd[1] !== 4) begin n_bad++; $display("FAIL dec_px1 got a=%0d d=%0d want a=1 d=4", wa[1], wd[1]); end
            n_cmp++; if (wb[1] !== 1) begin n_bad++; $display("FAIL dec_busy_last_write got %0d want 1", wb[1]); end
        end
        n_cmp++; if (done_busy !== 0) begin n_bad++; $display("FAIL dec_busy_at_done got %0d want 0", done_busy); end
    endtask

    task automatic test_average_f2;
        bit ok;
        int bad_per;
        clear_log();
        do_start(2'b10, 1'b0);
        wait_frame(300, 1'b0, ok);
        n_cmp++; if (ok !== 1'b1) begin n_bad++; $display("FAIL avg2_timeout got no DONE want DONE"); end
        n_cmp++; if (wa.size() !== 8) begin n_bad++; $display("FAIL avg2_count got %0d want 8", wa.size()); end
        if (wa.size() == 8) begin
            n_cmp++; if (wa[0] !== 0 || wd[0] !== 4) begin n_bad++; $display("FAIL avg2_px00 got a=%0d d=%0d want a=0 d=4", wa[0], wd[0]); end
            n_cmp++; if (wa[7] !== 7 || wd[7] !== 26) begin n_bad++; $display("FAIL avg2_px31 got a=%0d d=%0d want a=7 d=26", wa[7], wd[7]); end
            bad_per = 0;
            for (int i = 1; i < 8; i++) if (wc[i] - wc[i-1] != 7) bad_per++;
            n_cmp++; if (bad_per !== 0) begin n_bad++; $display("FAIL avg2_period got %0d off-period pixels want 0", bad_per); end
            for (int i = 0; i < 8; i++) begin
                n_cmp++;
                if (wd[i] !== exp_pix(2, 2, i % 4, i / 4)) begin
                    n_bad++;
                    $display("FAIL avg2_pix[%0d] got %0d want %0d", i, wd[i], exp_pix(2, 2, i % 4, i / 4));
                end
            end
        end
    endtask

    task automatic test_copy_stall;
        bit ok;
        int hold;
        clear_log();
        WR_READY = 1'b1;
        do_start(2'b11, 1'b0);
        ok = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(posedge CLK); #1;
            if (wa.size() >= 2) begin
                ok = 1'b1;
                break;
            end
        end
        n_cmp++; if (ok !== 1'b1) begin n_bad++; $display("FAIL cpy_second_write got none want write"); end
        WR_READY = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge CLK);
            if (WREN) break;
        end
        hold = 0;
        for (int k = 0; k < 6; k++) begin
            if (k > 0) begin
                if (k == 5) begin
                    @(posedge CLK); #1;
                    n_cmp++; if (wa.size() !== 2) begin n_bad++; $display("FAIL cpy_stall_no_write got %0d writes want 2", wa.size()); end
                    WR_READY = 1'b1;
                end
                @(negedge CLK);
            end
            if (WREN === 1'b1 && W_ADDR === 2 && PIXEL_OUT === 2) hold++;
        end
        n_cmp++; if (hold !== 6) begin n_bad++; $display("FAIL cpy_hold got %0d stable cycles want 6", hold); end
        wait_frame(400, 1'b0, ok);
        n_cmp++; if (ok !== 1'b1) begin n_bad++; $display("FAIL cpy_timeout got no DONE want DONE"); end
        n_cmp++; if (wa.size() !== 32) begin n_bad++; $display("FAIL cpy_count got %0d want 32", wa.size()); end
        if (wa.size() == 32) begin
            for (int i = 0; i < 32; i++) begin
                n_cmp++;
                if (wa[i] !== i || wd[i] !== exp_pix(3, 1, i % 8, i / 8)) begin
                    n_bad++;
                    $display("FAIL cpy_pix[%0d] got a=%0d d=%0d want a=%0d d=%0d", i, wa[i], wd[i], i, exp_pix(3, 1, i % 8, i / 8));
                end
            end
        end
    endtask

    task automatic test_reset_midframe;
        bit ok;
        int n_w;
        int n_d;
        clear_log();
        do_start(2'b10, 1'b1);
        ok = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(posedge CLK); #1;
            if (wa.size() >= 1) begin
                ok = 1'b1;
                break;
            end
        end
        n_cmp++; if (ok !== 1'b1) begin n_bad++; $display("FAIL rst_first_write got none want write"); end
        RESET = 1'b1;
        @(posedge CLK);
        @(negedge CLK);
        n_cmp++;
        if (WREN !== 1'b0 || BUSY !== 1'b0 || DONE !== 1'b0 || R_ADDR !== '0 || W_ADDR !== '0 || PIXEL_OUT !== '0) begin
            n_bad++;
            $display("FAIL rst_outputs got wren=%0b busy=%0b done=%0b ra=%0d wa=%0d px=%0d want all 0",
                     WREN, BUSY, DONE, R_ADDR, W_ADDR, PIXEL_OUT);
        end
        @(posedge CLK); #1;
        RESET = 1'b0;
        n_w = wa.size();
        n_d = done_cnt;
        repeat (40) @(posedge CLK);
        #1;
        n_cmp++; if (wa.size() !== n_w) begin n_bad++; $display("FAIL rst_no_write got %0d writes want %0d", wa.size(), n_w); end
        n_cmp++; if (done_cnt !== n_d) begin n_bad++; $display("FAIL rst_no_done got %0d want %0d", done_cnt, n_d); end
        clear_log();
        do_start(2'b10, 1'b1);
        wait_frame(200, 1'b0, ok);
        n_cmp++; if (ok !== 1'b1) begin n_bad++; $display("FAIL rst_restart_timeout got no DONE want DONE"); end
        n_cmp++; if (wa.size() !== 2) begin n_bad++; $display("FAIL rst_restart_count got %0d want 2", wa.size()); end
        if (wa.size() >= 1) begin
            n_cmp++;
            if (wa[0] !== 0 || wd[0] !== exp_pix(2, 4, 0, 0)) begin
                n_bad++;
                $display("FAIL rst_restart_px0 got a=%0d d=%0d want a=0 d=%0d", wa[0], wd[0], exp_pix(2, 4, 0, 0));
            end
        end
    endtask

    task automatic test_start_while_busy;
        bit ok;
        clear_log();
        do_start(2'b01, 1'b0);
        ok = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(posedge CLK); #1;
            if (wa.size() >= 3) begin
                ok = 1'b1;
                break;
            end
        end
        n_cmp++; if (ok !== 1'b1) begin n_bad++; $display("FAIL busy_third_write got none want write"); end
        MODE  = 2'b00;
        SCALE = 1'b1;
        START = 1'b1;
        @(posedge CLK); #1;
        START = 1'b0;
        wait_frame(300, 1'b0, ok);
        n_cmp++; if (ok !== 1'b1) begin n_bad++; $display("FAIL busy_timeout got no DONE want DONE"); end
        n_cmp++; if (wa.size() !== 8) begin n_bad++; $display("FAIL busy_count got %0d want 8", wa.size()); end
        if (wa.size() == 8) begin
            for (int i = 0; i < 8; i++) begin
                n_cmp++;
                if (wa[i] !== i || wd[i] !== exp_pix(1, 2, i % 4, i / 4)) begin
                    n_bad++;
                    $display("FAIL busy_pix[%0d] got a=%0d d=%0d want a=%0d d=%0d", i, wa[i], wd[i], i, exp_pix(1, 2, i % 4, i / 4));
                end
            end
        end
        repeat (5) @(posedge CLK);
        #1;
        n_cmp++; if (done_cnt !== 1) begin n_bad++; $display("FAIL busy_single_frame got %0d DONE pulses want 1", done_cnt); end
    endtask

    task automatic test_random_frames;
        bit ok;
        int m;
        int s;
        int f;
        int ow;
        int oh;
        for (int k = 0; k < 5; k++) begin
            m  = int'($urandom_range(0, 3));
            s  = int'($urandom_range(0, 1));
            f  = (m == 3) ? 1 : fac(s);
            ow = out_w_of(m, f);
            oh = out_h_of(m, f);
            clear_log();
            do_start(2'(m), 1'(s));
            wait_frame(8000, 1'b1, ok);
            n_cmp++; if (ok !== 1'b1) begin n_bad++; $display("FAIL rnd%0d_timeout mode=%0d scale=%0d got no DONE want DONE", k, m, s); end
            n_cmp++; if (wa.size() !== ow * oh) begin n_bad++; $display("FAIL rnd%0d_count mode=%0d scale=%0d got %0d want %0d", k, m, s, wa.size(), ow * oh); end
            if (wa.size() == ow * oh) begin
                for (int i = 0; i < ow * oh; i++) begin
                    n_cmp++;
                    if (wa[i] !== i || wd[i] !== exp_pix(m, f, i % ow, i / ow)) begin
                        n_bad++;
                        $display("FAIL rnd%0d_pix[%0d] mode=%0d scale=%0d got a=%0d d=%0d want a=%0d d=%0d",
                                 k, i, m, s, wa[i], wd[i], i, exp_pix(m, f, i % ow, i / ow));
                    end
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_replicate();
        test_decimate();
        test_average_f2();
        test_copy_stall();
        test_reset_midframe();
        test_start_while_busy();
        test_random_frames();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
